// File: rtl/score_engine.sv
// Score engine: buffers scoring events in a small FIFO and applies one per cycle
// to a saturating score with ghost-chain multiplier, extra-life pulses and high score.
module score_engine #(
    parameter int unsigned SCORE_W         = 24,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned PTS_DOT         = 10,
    parameter int unsigned PTS_PELLET      = 50,
    parameter int unsigned PTS_FRUIT       = 100,
    parameter int unsigned GHOST_BASE      = 200,
    parameter int unsigned GHOST_MAX_SHIFT = 3,
    parameter int unsigned LIFE_STEP       = 10000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               ev_valid,
    input  logic [1:0]         ev_code,
    output logic               ev_ready,
    input  logic               freeze,
    input  logic               chain_clear,
    input  logic               score_clr,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] high_score,
    output logic               extra_life,
    output logic               sat,
    output logic               busy
);

    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned SUM_W   = SCORE_W + 1;
    localparam int unsigned CHAIN_W = (GHOST_MAX_SHIFT < 1) ? 1 : $clog2(GHOST_MAX_SHIFT + 1);

    localparam logic [CNT_W-1:0]   CNT_FULL  = CNT_W'(FIFO_DEPTH);
    localparam logic [CHAIN_W-1:0] CHAIN_MAX = CHAIN_W'(GHOST_MAX_SHIFT);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [SCORE_W-1:0] THR_INIT  = SCORE_W'(LIFE_STEP);
    localparam logic [SUM_W-1:0]   THR_STEP  = SUM_W'(LIFE_STEP);
    // A step that does not fit in the score range can never be reached.
    localparam logic               LIFE_FITS = ((64'(LIFE_STEP) >> SCORE_W) == 64'd0) && (LIFE_STEP != 0);

    typedef enum logic [1:0] {
        EV_DOT    = 2'b00,
        EV_PELLET = 2'b01,
        EV_GHOST  = 2'b10,
        EV_FRUIT  = 2'b11
    } ev_code_t;

    logic [1:0]         mem_q [FIFO_DEPTH];
    logic [1:0]         mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W-1:0] high_score_q, high_score_d;
    logic [CHAIN_W-1:0] chain_q, chain_d;
    logic [SCORE_W-1:0] thresh_q, thresh_d;
    logic               life_en_q, life_en_d;
    logic               extra_life_q, extra_life_d;
    logic               sat_q, sat_d;

    logic               push;
    logic               pop;
    ev_code_t           head;
    logic [SUM_W-1:0]   incr;
    logic [SUM_W-1:0]   sum;
    logic [SUM_W-1:0]   thr_sum;

    assign ev_ready   = (count_q != CNT_FULL) && !score_clr;
    assign busy       = (count_q != '0);
    assign score      = score_q;
    assign high_score = high_score_q;
    assign extra_life = extra_life_q;
    assign sat        = sat_q;

    // Increment selection for the event at the FIFO head.
    always_comb begin
        head = ev_code_t'(mem_q[rd_ptr_q]);
        incr = '0;
        case (head)
            EV_DOT:    incr = SUM_W'(PTS_DOT);
            EV_PELLET: incr = SUM_W'(PTS_PELLET);
            EV_GHOST:  incr = SUM_W'(GHOST_BASE) << chain_q;
            EV_FRUIT:  incr = SUM_W'(PTS_FRUIT);
            default:   incr = '0;
        endcase
        sum     = {1'b0, score_q} + incr;
        thr_sum = {1'b0, thresh_q} + THR_STEP;
    end

    // Next-state logic: FIFO bookkeeping, score update, chain and life tracking.
    always_comb begin
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        score_d      = score_q;
        chain_d      = chain_q;
        thresh_d     = thresh_q;
        life_en_d    = life_en_q;
        sat_d        = sat_q;
        extra_life_d = 1'b0;
        high_score_d = (score_q > high_score_q) ? score_q : high_score_q;

        push = ev_valid && ev_ready;
        pop  = (count_q != '0) && !freeze && !score_clr;

        if (score_clr) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            score_d   = '0;
            chain_d   = '0;
            thresh_d  = THR_INIT;
            life_en_d = LIFE_FITS;
            sat_d     = 1'b0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = ev_code;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);

            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                if (sum[SCORE_W]) begin
                    score_d = SCORE_MAX;
                    sat_d   = 1'b1;
                end else begin
                    score_d = sum[SCORE_W-1:0];
                end
                if (head == EV_GHOST && chain_q != CHAIN_MAX) begin
                    chain_d = chain_q + 1'b1;
                end
                // One pulse per event; thresholds beyond the range stop further pulses.
                if (life_en_q && score_d >= thresh_q) begin
                    extra_life_d = 1'b1;
                    if (thr_sum[SCORE_W]) begin
                        life_en_d = 1'b0;
                    end else begin
                        thresh_d = thr_sum[SCORE_W-1:0];
                    end
                end
            end

            // Clear wins over a coincident ghost's chain advance.
            if (chain_clear) begin
                chain_d = '0;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            score_q      <= '0;
            high_score_q <= '0;
            chain_q      <= '0;
            thresh_q     <= THR_INIT;
            life_en_q    <= LIFE_FITS;
            extra_life_q <= 1'b0;
            sat_q        <= 1'b0;
        end else begin
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            score_q      <= score_d;
            high_score_q <= high_score_d;
            chain_q      <= chain_d;
            thresh_q     <= thresh_d;
            life_en_q    <= life_en_d;
            extra_life_q <= extra_life_d;
            sat_q        <= sat_d;
        end
    end

endmodule

// File: tb/tb_score_engine.sv
// Directed self-checking bench for score_engine: default build plus a 12-bit
// score build for saturation.
module tb_score_engine;

    logic        clk;
    logic        reset_n;
    logic        ev_valid, freeze, chain_clear, score_clr;
    logic [1:0]  ev_code;
    logic        ev_ready, extra_life, sat, busy;
    logic [23:0] score, high_score;

    logic        ev_valid12, freeze12, chain_clear12, score_clr12;
    logic [1:0]  ev_code12;
    logic        ev_ready12, extra_life12, sat12, busy12;
    logic [11:0] score12, high_score12;

    int n_chk;
    int n_pass;
    int life_cnt;
    int life12_cnt;

    score_engine dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ev_valid    (ev_valid),
        .ev_code     (ev_code),
        .ev_ready    (ev_ready),
        .freeze      (freeze),
        .chain_clear (chain_clear),
        .score_clr   (score_clr),
        .score       (score),
        .high_score  (high_score),
        .extra_life  (extra_life),
        .sat         (sat),
        .busy        (busy)
    );

    score_engine #(.SCORE_W(12), .LIFE_STEP(100000)) dut12 (
        .clk         (clk),
        .reset_n     (reset_n),
        .ev_valid    (ev_valid12),
        .ev_code     (ev_code12),
        .ev_ready    (ev_ready12),
        .freeze      (freeze12),
        .chain_clear (chain_clear12),
        .score_clr   (score_clr12),
        .score       (score12),
        .high_score  (high_score12),
        .extra_life  (extra_life12),
        .sat         (sat12),
        .busy        (busy12)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Advance one clock and sample just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (extra_life === 1'b1) life_cnt++;
        if (extra_life12 === 1'b1) life12_cnt++;
    endtask

    task automatic push_n(input logic [1:0] code, input int n);
        ev_valid = 1'b1;
        ev_code  = code;
        for (int i = 0; i < n; i++) step();
        ev_valid = 1'b0;
    endtask

    task automatic push12_n(input logic [1:0] code, input int n);
        ev_valid12 = 1'b1;
        ev_code12  = code;
        for (int i = 0; i < n; i++) step();
        ev_valid12 = 1'b0;
    endtask

    task automatic clear();
        score_clr = 1'b1;
        step();
        score_clr = 1'b0;
    endtask

    initial begin
        n_chk = 0; n_pass = 0; life_cnt = 0; life12_cnt = 0;
        reset_n = 1'b0;
        ev_valid = 0; ev_code = 0; freeze = 0; chain_clear = 0; score_clr = 0;
        ev_valid12 = 0; ev_code12 = 0; freeze12 = 0; chain_clear12 = 0; score_clr12 = 0;
        step(); step();
        reset_n = 1'b1;

        chk("rst_score", 32'(score), 0);
        chk("rst_high", 32'(high_score), 0);
        chk("rst_ready", 32'(ev_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_sat", 32'(sat), 0);

        // Three dots back to back: score 10/20/30 one edge after each push.
        ev_valid = 1'b1; ev_code = 2'b00;
        step(); chk("dot_n0", 32'(score), 0); chk("dot_busy", 32'(busy), 1);
        step(); chk("dot_n1", 32'(score), 10);
        step(); chk("dot_n2", 32'(score), 20);
        ev_valid = 1'b0;
        step(); chk("dot_n3", 32'(score), 30); chk("dot_idle", 32'(busy), 0);
        chk("high_lag", 32'(high_score), 20);
        step(); chk("high_30", 32'(high_score), 30);

        // Ghost chain 200,400,800,1600,1600 then clear restarts at 200.
        clear();
        chk("clr_score", 32'(score), 0);
        ev_valid = 1'b1; ev_code = 2'b10;
        step();
        step(); chk("ghost1", 32'(score), 200);
        step(); chk("ghost2", 32'(score), 600);
        step(); chk("ghost3", 32'(score), 1400);
        step(); chk("ghost4", 32'(score), 3000);
        ev_valid = 1'b0;
        step(); chk("ghost5", 32'(score), 4600);
        chain_clear = 1'b1; step(); chain_clear = 1'b0;
        push_n(2'b10, 1);
        step(); chk("ghost_after_clr", 32'(score), 4800);

        // Freeze: only four accepted, held offer taken once space frees.
        clear();
        freeze = 1'b1; ev_valid = 1'b1; ev_code = 2'b00;
        for (int i = 0; i < 4; i++) step();
        chk("frz_ready", 32'(ev_ready), 0);
        step(); step();
        chk("frz_score", 32'(score), 0);
        chk("frz_busy", 32'(busy), 1);
        freeze = 1'b0;
        step(); chk("frz_pop1", 32'(score), 10); chk("frz_ready1", 32'(ev_ready), 1);
        step(); chk("frz_pop2", 32'(score), 20);
        ev_valid = 1'b0;
        step(); chk("frz_pop3", 32'(score), 30);
        step(); chk("frz_pop4", 32'(score), 40);
        step(); chk("frz_held", 32'(score), 50); chk("frz_empty", 32'(busy), 0);

        // Extra life at 10000 (crossed by fruit) and exactly at 20000.
        clear();
        life_cnt = 0;
        push_n(2'b00, 999);
        step(); chk("el_9990", 32'(score), 9990); chk("el_none", life_cnt, 0);
        push_n(2'b11, 1);
        step(); chk("el_10090", 32'(score), 10090); chk("el_pulse", 32'(extra_life), 1);
        step(); chk("el_one_cycle", 32'(extra_life), 0);
        push_n(2'b11, 99);
        step(); chk("el_19990", 32'(score), 19990); chk("el_cnt1", life_cnt, 1);
        push_n(2'b00, 1);
        step(); chk("el_20000", 32'(score), 20000); chk("el_cnt2", life_cnt, 2);

        // score_clr drops queued events and the concurrent offer.
        clear();
        push_n(2'b10, 1);
        step(); chk("sc_pre", 32'(score), 200);
        freeze = 1'b1;
        push_n(2'b00, 3);
        score_clr = 1'b1; ev_valid = 1'b1;
        #1 chk("sc_ready", 32'(ev_ready), 0);
        step();
        score_clr = 1'b0; ev_valid = 1'b0; freeze = 1'b0;
        chk("sc_busy", 32'(busy), 0); chk("sc_score", 32'(score), 0);
        step(); step(); chk("sc_stays0", 32'(score), 0);
        push_n(2'b10, 1);
        step(); chk("sc_chain0", 32'(score), 200);

        // Reset mid-stream returns everything to reset values.
        push_n(2'b10, 1);
        freeze = 1'b1;
        push_n(2'b00, 2);
        reset_n = 1'b0; ev_valid = 1'b1;
        step();
        chk("mr_score", 32'(score), 0);
        chk("mr_high", 32'(high_score), 0);
        chk("mr_busy", 32'(busy), 0);
        chk("mr_ready", 32'(ev_ready), 1);
        reset_n = 1'b1; ev_valid = 1'b0; freeze = 1'b0;
        push_n(2'b10, 1);
        step(); chk("mr_chain0", 32'(score), 200);

        // 12-bit build: saturation, sticky sat, clear keeps high score.
        push12_n(2'b11, 40);
        step(); chk("s12_4000", 32'(score12), 4000); chk("s12_nosat", 32'(sat12), 0);
        push12_n(2'b11, 1);
        step(); chk("s12_sat_score", 32'(score12), 4095); chk("s12_sat", 32'(sat12), 1);
        push12_n(2'b00, 1);
        step(); chk("s12_hold", 32'(score12), 4095); chk("s12_sticky", 32'(sat12), 1);
        step(); chk("s12_high", 32'(high_score12), 4095);
        score_clr12 = 1'b1; step(); score_clr12 = 1'b0;
        chk("s12_clr_score", 32'(score12), 0);
        chk("s12_clr_sat", 32'(sat12), 0);
        step(); chk("s12_clr_high", 32'(high_score12), 4095);
        chk("s12_no_life", life12_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
